// File: rtl/rice_core_env_if.sv
// Interface between ex_stage and the machine-mode trap/CSR environment.
//  env modport (environment side):
//   out: privilege_level  current privilege (2'b11 M, 2'b00 U)
//        trap_pc          trap vector target (mtvec, direct mode)
//        return_pc        mret target (mepc)
//   in : exception_valid  ex_stage reports an exception this cycle
//        exception_code   value captured into mcause
//        exception_value  value captured into mtval
//        exception_pc     PC of the faulting instruction, captured into mepc
//        mret             ex_stage executes mret this cycle
//        inst_retired     an instruction retires this cycle
//  ex modport is the mirror image, used by ex_stage (or a testbench).
interface rice_core_env_if #(
    parameter int XLEN = 32
);
    logic [1:0]      privilege_level;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] return_pc;
    logic            exception_valid;
    logic [XLEN-1:0] exception_code;
    logic [XLEN-1:0] exception_value;
    logic [XLEN-1:0] exception_pc;
    logic            mret;
    logic            inst_retired;

    modport env (
        output privilege_level, trap_pc, return_pc,
        input  exception_valid, exception_code, exception_value, exception_pc,
        input  mret, inst_retired
    );

    modport ex (
        input  privilege_level, trap_pc, return_pc,
        output exception_valid, exception_code, exception_value, exception_pc,
        output mret, inst_retired
    );
endinterface

// File: rtl/rice_core_env.sv
// Machine-mode trap/CSR environment.
// Holds the privilege level, mstatus (MIE/MPIE/MPP), mtvec, mepc, mcause, mtval,
// mscratch and the 64-bit mcycle/minstret counters. Captures exceptions and mret
// reported by ex_stage, supplies trap/return PCs and serves CSR accesses.
// Ports:
//  i_clk          clock
//  i_rst          synchronous reset, active-high
//  env_if         rice_core_env_if.env (privilege_level/trap_pc/return_pc out, events in)
//  i_csr_valid    CSR access strobe
//  i_csr_address  CSR address
//  i_csr_op       00 read, 01 write, 10 set, 11 clear
//  i_csr_wdata    write/set/clear operand
//  o_csr_rdata    current value of the addressed CSR (combinational)
//  o_csr_illegal  access is illegal (combinational, qualified by i_csr_valid)
module rice_core_env #(
    parameter int              XLEN         = 32,
    parameter bit              SUPPORT_USER = 1'b0,
    parameter logic [XLEN-1:0] RESET_MTVEC  = '0,
    parameter logic [XLEN-1:0] HART_ID      = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    rice_core_env_if.env     env_if,
    input  logic             i_csr_valid,
    input  logic [11:0]      i_csr_address,
    input  logic [1:0]       i_csr_op,
    input  logic [XLEN-1:0]  i_csr_wdata,
    output logic [XLEN-1:0]  o_csr_rdata,
    output logic             o_csr_illegal
);
    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_M = 2'b11
    } priv_t;

    priv_t           priv_reg, priv_next;
    logic            mie_reg, mie_next;
    logic            mpie_reg, mpie_next;
    logic [1:0]      mpp_reg, mpp_next;
    logic [XLEN-1:0] mtvec_reg, mtvec_next;
    logic [XLEN-1:0] mepc_reg, mepc_next;
    logic [XLEN-1:0] mcause_reg, mcause_next;
    logic [XLEN-1:0] mtval_reg, mtval_next;
    logic [XLEN-1:0] mscratch_reg, mscratch_next;
    logic [63:0]     mcycle_reg, mcycle_next;
    logic [63:0]     minstret_reg, minstret_next;

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] misa_val;
    logic [XLEN-1:0] csr_rdata;
    logic [XLEN-1:0] csr_wval;
    logic            csr_mapped;
    logic            csr_read_only;
    logic            csr_is_write;
    logic            csr_illegal;
    logic            csr_commit;
    logic            exc;

    assign exc = env_if.exception_valid;

    // Only MIE, MPIE and MPP are implemented; every other mstatus bit reads 0.
    always_comb begin
        mstatus_val        = '0;
        mstatus_val[3]     = mie_reg;
        mstatus_val[7]     = mpie_reg;
        mstatus_val[12:11] = mpp_reg;
    end

    // misa: MXL in the top two bits, I always present, U when user mode exists.
    always_comb begin
        misa_val                  = '0;
        misa_val[XLEN-1:XLEN-2]   = (XLEN == 32) ? 2'b01 : 2'b10;
        misa_val[8]               = 1'b1;
        misa_val[20]              = SUPPORT_USER;
    end

    // Address decode and read mux.
    always_comb begin
        csr_rdata     = '0;
        csr_mapped    = 1'b1;
        csr_read_only = 1'b0;
        case (i_csr_address)
            12'h300: csr_rdata = mstatus_val;
            12'h301: begin
                csr_rdata     = misa_val;
                csr_read_only = 1'b1;
            end
            12'h305: csr_rdata = mtvec_reg;
            12'h340: csr_rdata = mscratch_reg;
            12'h341: csr_rdata = mepc_reg;
            12'h342: csr_rdata = mcause_reg;
            12'h343: csr_rdata = mtval_reg;
            12'hB00: csr_rdata = mcycle_reg[XLEN-1:0];
            12'hB02: csr_rdata = minstret_reg[XLEN-1:0];
            12'hB80: begin
                if (XLEN == 32) csr_rdata = XLEN'(mcycle_reg[63:32]);
                else            csr_mapped = 1'b0;
            end
            12'hB82: begin
                if (XLEN == 32) csr_rdata = XLEN'(minstret_reg[63:32]);
                else            csr_mapped = 1'b0;
            end
            12'hF14: begin
                csr_rdata     = HART_ID;
                csr_read_only = 1'b1;
            end
            default: csr_mapped = 1'b0;
        endcase
    end

    assign csr_is_write = (i_csr_op != 2'b00);
    assign csr_illegal  = !csr_mapped
                        || (csr_is_write && (csr_read_only || i_csr_address[11:10] == 2'b11))
                        || (priv_reg == PRIV_U);
    assign csr_commit   = i_csr_valid && csr_is_write && !csr_illegal && !exc;

    always_comb begin
        case (i_csr_op)
            2'b01:   csr_wval = i_csr_wdata;
            2'b10:   csr_wval = csr_rdata | i_csr_wdata;
            2'b11:   csr_wval = csr_rdata & ~i_csr_wdata;
            default: csr_wval = csr_rdata;
        endcase
    end

    function automatic logic mpp_legal(input logic [1:0] v);
        return (v == 2'b11) || (SUPPORT_USER && v == 2'b00);
    endfunction

    // Next-state: CSR write first, then mret, then exception, so later
    // assignments implement the exception > mret > CSR write priority.
    always_comb begin
        priv_next     = priv_reg;
        mie_next      = mie_reg;
        mpie_next     = mpie_reg;
        mpp_next      = mpp_reg;
        mtvec_next    = mtvec_reg;
        mepc_next     = mepc_reg;
        mcause_next   = mcause_reg;
        mtval_next    = mtval_reg;
        mscratch_next = mscratch_reg;
        mcycle_next   = mcycle_reg + 64'd1;
        minstret_next = minstret_reg + {63'd0, env_if.inst_retired && !exc};

        if (csr_commit) begin
            case (i_csr_address)
                12'h300: begin
                    mie_next  = csr_wval[3];
                    mpie_next = csr_wval[7];
                    if (mpp_legal(csr_wval[12:11])) mpp_next = csr_wval[12:11];
                end
                12'h305: mtvec_next    = {csr_wval[XLEN-1:2], 2'b00};
                12'h340: mscratch_next = csr_wval;
                12'h341: mepc_next     = {csr_wval[XLEN-1:2], 2'b00};
                12'h342: mcause_next   = csr_wval;
                12'h343: mtval_next    = csr_wval;
                // Writing a counter half replaces it and suppresses the increment.
                12'hB00: begin
                    if (XLEN == 32) mcycle_next = {mcycle_reg[63:32], csr_wval[31:0]};
                    else            mcycle_next = 64'(csr_wval);
                end
                12'hB02: begin
                    if (XLEN == 32) minstret_next = {minstret_reg[63:32], csr_wval[31:0]};
                    else            minstret_next = 64'(csr_wval);
                end
                12'hB80: mcycle_next   = {csr_wval[31:0], mcycle_reg[31:0]};
                12'hB82: minstret_next = {csr_wval[31:0], minstret_reg[31:0]};
                default: ;
            endcase
        end

        if (env_if.mret) begin
            priv_next = priv_t'(mpp_reg);
            mie_next  = mpie_reg;
            mpie_next = 1'b1;
            mpp_next  = SUPPORT_USER ? PRIV_U : PRIV_M;
        end

        if (exc) begin
            mepc_next   = {env_if.exception_pc[XLEN-1:2], 2'b00};
            mcause_next = env_if.exception_code;
            mtval_next  = env_if.exception_value;
            mpie_next   = mie_reg;
            mie_next    = 1'b0;
            mpp_next    = priv_reg;
            priv_next   = PRIV_M;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            priv_reg     <= PRIV_M;
            mie_reg      <= 1'b0;
            mpie_reg     <= 1'b0;
            mpp_reg      <= PRIV_M;
            mtvec_reg    <= {RESET_MTVEC[XLEN-1:2], 2'b00};
            mepc_reg     <= '0;
            mcause_reg   <= '0;
            mtval_reg    <= '0;
            mscratch_reg <= '0;
            mcycle_reg   <= '0;
            minstret_reg <= '0;
        end else begin
            priv_reg     <= priv_next;
            mie_reg      <= mie_next;
            mpie_reg     <= mpie_next;
            mpp_reg      <= mpp_next;
            mtvec_reg    <= mtvec_next;
            mepc_reg     <= mepc_next;
            mcause_reg   <= mcause_next;
            mtval_reg    <= mtval_next;
            mscratch_reg <= mscratch_next;
            mcycle_reg   <= mcycle_next;
            minstret_reg <= minstret_next;
        end
    end

    assign env_if.privilege_level = priv_reg;
    assign env_if.trap_pc         = {mtvec_reg[XLEN-1:2], 2'b00};
    assign env_if.return_pc       = {mepc_reg[XLEN-1:2], 2'b00};
    assign o_csr_rdata            = csr_rdata;
    assign o_csr_illegal          = i_csr_valid && csr_illegal;
endmodule

// File: tb/tb_rice_core_env.sv
// Testbench for rice_core_env: one M-only instance (dut0) and one with user
// mode (dut1). Stimulus pushes expected observations into a scoreboard queue;
// a monitor on the falling edge pops and compares them.
module tb_rice_core_env;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        csr_valid [2];
    logic [11:0] csr_addr  [2];
    logic [1:0]  csr_op    [2];
    logic [31:0] csr_wdata [2];
    logic [31:0] csr_rdata [2];
    logic        csr_ill   [2];

    rice_core_env_if #(.XLEN(32)) if0 ();
    rice_core_env_if #(.XLEN(32)) if1 ();

    rice_core_env #(.XLEN(32), .SUPPORT_USER(1'b0), .RESET_MTVEC(32'h0000_1007), .HART_ID(32'd0)) dut0 (
        .i_clk(clk), .i_rst(rst), .env_if(if0),
        .i_csr_valid(csr_valid[0]), .i_csr_address(csr_addr[0]), .i_csr_op(csr_op[0]),
        .i_csr_wdata(csr_wdata[0]), .o_csr_rdata(csr_rdata[0]), .o_csr_illegal(csr_ill[0])
    );

    rice_core_env #(.XLEN(32), .SUPPORT_USER(1'b1), .RESET_MTVEC(32'h0000_0000), .HART_ID(32'd3)) dut1 (
        .i_clk(clk), .i_rst(rst), .env_if(if1),
        .i_csr_valid(csr_valid[1]), .i_csr_address(csr_addr[1]), .i_csr_op(csr_op[1]),
        .i_csr_wdata(csr_wdata[1]), .o_csr_rdata(csr_rdata[1]), .o_csr_illegal(csr_ill[1])
    );

    // kind: 0 csr_rdata, 1 csr_illegal, 2 privilege, 3 trap_pc, 4 return_pc
    typedef struct {
        int          s;
        int          kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    int    n_total = 0;
    int    n_pass  = 0;

    function automatic logic [31:0] observe(input int s, input int kind);
        logic [31:0] v;
        v = '0;
        case (kind)
            0: v = csr_rdata[s];
            1: v = {31'd0, csr_ill[s]};
            2: v = (s == 0) ? {30'd0, if0.privilege_level} : {30'd0, if1.privilege_level};
            3: v = (s == 0) ? if0.trap_pc : if1.trap_pc;
            default: v = (s == 0) ? if0.return_pc : if1.return_pc;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            item_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = observe(e.s, e.kind);
            n_total++;
            if (act === e.exp) begin
                n_pass++;
                $display("check dut%0d %s: got %h", e.s, e.name, act);
            end else begin
                $display("FAIL dut%0d %s: got %h expected %h", e.s, e.name, act, e.exp);
            end
        end
    end

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            csr_valid[i] = 1'b0;
            csr_addr[i]  = '0;
            csr_op[i]    = '0;
            csr_wdata[i] = '0;
        end
        if0.exception_valid = 1'b0; if0.exception_code = '0; if0.exception_value = '0;
        if0.exception_pc = '0; if0.mret = 1'b0; if0.inst_retired = 1'b0;
        if1.exception_valid = 1'b0; if1.exception_code = '0; if1.exception_value = '0;
        if1.exception_pc = '0; if1.mret = 1'b0; if1.inst_retired = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic csr(input int s, input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_valid[s] = 1'b1;
        csr_op[s]    = op;
        csr_addr[s]  = a;
        csr_wdata[s] = d;
    endtask

    task automatic chk(input int s, input int kind, input logic [31:0] exp, input string name);
        item_t e;
        e.s = s; e.kind = kind; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic rd(input int s, input logic [11:0] a, input logic [31:0] exp, input string name);
        csr(s, 2'b00, a, 32'd0);
        chk(s, 0, exp, name);
    endtask

    task automatic raise(input int s, input logic [31:0] code, input logic [31:0] val, input logic [31:0] pc);
        if (s == 0) begin
            if0.exception_valid = 1'b1; if0.exception_code = code;
            if0.exception_value = val;  if0.exception_pc = pc;
        end else begin
            if1.exception_valid = 1'b1; if1.exception_code = code;
            if1.exception_value = val;  if1.exception_pc = pc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        repeat (10) cyc();

        n_total++;
        if (if0.privilege_level === 2'b11 && if0.trap_pc === 32'h0000_1004) begin
            n_pass++;
            $display("check dut0 direct_reset_state: priv %b trap_pc %h", if0.privilege_level, if0.trap_pc);
        end else begin
            $display("FAIL dut0 direct_reset_state: priv %b trap_pc %h", if0.privilege_level, if0.trap_pc);
        end
        n_total++;
        if (if1.privilege_level === 2'b11 && if1.trap_pc === 32'h0000_0000) begin
            n_pass++;
            $display("check dut1 direct_reset_state: priv %b trap_pc %h", if1.privilege_level, if1.trap_pc);
        end else begin
            $display("FAIL dut1 direct_reset_state: priv %b trap_pc %h", if1.privilege_level, if1.trap_pc);
        end

        // Reset state after 10 idle cycles
        rd(0, 12'hB00, 32'd10, "mcycle_after_10"); chk(0, 2, 32'd3, "priv_reset");
        chk(0, 3, 32'h0000_1004, "trap_pc_reset"); chk(1, 3, 32'h0, "trap_pc_reset");
        rd(1, 12'h300, 32'h0000_1800, "mstatus_reset"); chk(1, 2, 32'd3, "priv_reset");
        cyc();
        rd(0, 12'hB02, 32'd0, "minstret_reset"); rd(1, 12'hB80, 32'd0, "mcycleh_reset");
        cyc();

        // mtvec WARL and exception capture
        csr(0, 2'b01, 12'h305, 32'h8000_0103); cyc();
        chk(0, 3, 32'h8000_0100, "trap_pc_written");
        csr(0, 2'b10, 12'h300, 32'h0000_0008); cyc();
        rd(0, 12'h300, 32'h0000_1808, "mstatus_mie_set"); cyc();
        raise(0, 32'd2, 32'h0000_DEAD, 32'h0000_0100); cyc();
        rd(0, 12'h341, 32'h0000_0100, "mepc_exc"); chk(0, 2, 32'd3, "priv_exc");
        chk(0, 4, 32'h0000_0100, "return_pc_exc"); cyc();
        rd(0, 12'h342, 32'd2, "mcause_exc"); cyc();
        rd(0, 12'h343, 32'h0000_DEAD, "mtval_exc"); cyc();
        rd(0, 12'h300, 32'h0000_1880, "mstatus_exc"); cyc();

        // mstatus WARL on M-only core, read-only and unmapped CSRs
        csr(0, 2'b01, 12'h300, 32'h0000_1088); cyc();
        rd(0, 12'h300, 32'h0000_1888, "mstatus_mpp01_kept"); cyc();
        csr(0, 2'b11, 12'h300, 32'h0000_0800); cyc();
        rd(0, 12'h300, 32'h0000_1888, "mstatus_mpp_clear_kept"); cyc();
        csr(0, 2'b01, 12'h301, 32'h0); chk(0, 1, 32'd1, "misa_write_illegal");
        rd(1, 12'hF14, 32'd3, "mhartid"); chk(1, 1, 32'd0, "mhartid_read_legal"); cyc();
        rd(0, 12'h7C0, 32'd0, "unmapped_rdata"); chk(0, 1, 32'd1, "unmapped_illegal");
        csr(1, 2'b10, 12'hB00, 32'h0); chk(1, 1, 32'd0, "mcycle_set_legal"); cyc();

        // mcycle carry across halves
        csr(0, 2'b01, 12'hB00, 32'hFFFF_FFFF); cyc();
        csr(0, 2'b01, 12'hB80, 32'h0); cyc();
        rd(0, 12'hB80, 32'd0, "mcycleh_written"); cyc();
        rd(0, 12'hB00, 32'd0, "mcycle_wrapped"); cyc();
        rd(0, 12'hB80, 32'd1, "mcycleh_carry"); cyc();

        // minstret carry; write cycle suppresses the increment
        csr(0, 2'b01, 12'hB02, 32'hFFFF_FFFF); cyc();
        csr(0, 2'b01, 12'hB82, 32'h0); if0.inst_retired = 1'b1; cyc();
        rd(0, 12'hB02, 32'hFFFF_FFFF, "minstret_no_inc_on_write"); if0.inst_retired = 1'b1; cyc();
        rd(0, 12'hB82, 32'd1, "minstreth_carry"); cyc();
        rd(0, 12'hB02, 32'd0, "minstret_wrapped"); cyc();

        // Exception + mret + retire + CSR write in one cycle
        raise(0, 32'd11, 32'd0, 32'h0000_0200); if0.mret = 1'b1; if0.inst_retired = 1'b1;
        csr(0, 2'b01, 12'h341, 32'h0000_0040); cyc();
        rd(0, 12'h341, 32'h0000_0200, "mepc_priority"); chk(0, 2, 32'd3, "priv_priority"); cyc();
        rd(0, 12'hB02, 32'd0, "minstret_blocked"); cyc();
        rd(0, 12'h300, 32'h0000_1880, "mstatus_priority"); cyc();
        if0.mret = 1'b1; cyc();
        rd(0, 12'h300, 32'h0000_1888, "mstatus_mret_m"); chk(0, 2, 32'd3, "priv_mret_m"); cyc();

        // User mode round trip
        csr(1, 2'b01, 12'h300, 32'h0000_0080); cyc();
        rd(1, 12'h300, 32'h0000_0080, "mstatus_mpp_u"); cyc();
        if1.mret = 1'b1; cyc();
        csr(1, 2'b00, 12'h340, 32'h0); chk(1, 1, 32'd1, "umode_read_illegal");
        chk(1, 2, 32'd0, "priv_user"); cyc();
        csr(1, 2'b01, 12'h340, 32'h0000_0055); chk(1, 1, 32'd1, "umode_write_illegal"); cyc();
        raise(1, 32'd8, 32'd0, 32'h0000_0300); cyc();
        chk(1, 2, 32'd3, "priv_after_ecall");
        rd(1, 12'h300, 32'h0000_0080, "mstatus_after_ecall"); cyc();
        rd(1, 12'h340, 32'd0, "mscratch_unchanged"); cyc();
        rd(1, 12'h341, 32'h0000_0300, "mepc_ecall"); cyc();
        rd(1, 12'h342, 32'd8, "mcause_ecall"); cyc();
        csr(1, 2'b01, 12'h341, 32'h0000_0123); cyc();
        rd(1, 12'h341, 32'h0000_0120, "mepc_warl"); chk(1, 4, 32'h0000_0120, "return_pc_warl"); cyc();

        // Reset mid-operation overrides concurrent events
        rst = 1'b1;
        raise(0, 32'd5, 32'd1, 32'h0000_0400);
        csr(1, 2'b01, 12'h340, 32'h0000_0077);
        cyc();
        rst = 1'b0;
        n_total++;
        if (if0.privilege_level === 2'b11 && if0.trap_pc === 32'h0000_1004 && if0.return_pc === 32'h0) begin
            n_pass++;
            $display("check dut0 direct_mid_reset: priv %b trap_pc %h return_pc %h",
                     if0.privilege_level, if0.trap_pc, if0.return_pc);
        end else begin
            $display("FAIL dut0 direct_mid_reset: priv %b trap_pc %h return_pc %h",
                     if0.privilege_level, if0.trap_pc, if0.return_pc);
        end
        rd(0, 12'hB00, 32'd0, "mcycle_after_rst"); chk(0, 2, 32'd3, "priv_after_rst");
        chk(0, 3, 32'h0000_1004, "trap_pc_after_rst"); chk(0, 4, 32'h0, "return_pc_after_rst");
        rd(1, 12'h340, 32'd0, "mscratch_after_rst"); cyc();
        rd(0, 12'h300, 32'h0000_1800, "mstatus_after_rst"); cyc();

        @(negedge clk);
        #1;
        if (n_total > 0 && n_pass == n_total) begin
            $display("PASS %0d/%0d checks passed", n_pass, n_total);
        end else begin
            $display("FAIL %0d/%0d checks passed", n_pass, n_total);
        end
        $finish;
    end
endmodule
